// File: rtl/alu_arbiter_if.sv
// Instruction encoding shared with the alu, and the request/ALU/response bundle
// between issue logic, the arbiter and the alu instance.
package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    kADDU = 4'h0,
    kSUBU = 4'h1,
    kAND  = 4'h2,
    kOR   = 4'h3,
    kXOR  = 4'h4,
    kSLT  = 4'h5,
    kBEQZ = 4'h6,
    kBNEZ = 4'h7
  } instruction_s;
endpackage

interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0][31:0]  req_rd_i;
  logic [NUM_REQ-1:0][31:0]  req_rs_i;
  instruction_s [NUM_REQ-1:0] req_op_i;
  logic [31:0]               alu_rd_o;
  logic [31:0]               alu_rs_o;
  instruction_s              alu_op_o;
  logic [31:0]               alu_result_i;
  logic                      alu_jump_now_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [ID_W-1:0]           rsp_id_o;
  logic [31:0]               rsp_result_o;
  logic                      rsp_jump_o;

  modport slave (
    input  req_valid_i, req_rd_i, req_rs_i, req_op_i,
           alu_result_i, alu_jump_now_i, rsp_ready_i,
    output req_ready_o, alu_rd_o, alu_rs_o, alu_op_o,
           rsp_valid_o, rsp_id_o, rsp_result_o, rsp_jump_o
  );

  modport master (
    output req_valid_i, req_rd_i, req_rs_i, req_op_i,
           alu_result_i, alu_jump_now_i, rsp_ready_i,
    input  req_ready_o, alu_rd_o, alu_rs_o, alu_op_o,
           rsp_valid_o, rsp_id_o, rsp_result_o, rsp_jump_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between NUM_REQ requesters: arbitrate, register operands,
// capture the result a cycle later. Define ALU_ARB_RR_EN for round-robin, else fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic         clk,
  input  logic         n_reset_i,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] grant;
  logic            grant_vld;
  logic            can_accept;
  logic            accept;
  logic [31:0]     alu_rd_q, alu_rs_q;
  instruction_s    alu_op_q;
  logic [31:0]     rsp_result_q;
  logic [ID_W-1:0] rsp_id_q;
  logic            rsp_jump_q;

  always_comb begin : arbitrate
    int unsigned idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef ALU_ARB_RR_EN
      idx = 32'(last_q) + k + 1;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`else
      idx = k;
`endif
      if (!grant_vld && bus.req_valid_i[ID_W'(idx)]) begin
        grant_vld = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

  assign can_accept = n_reset_i && ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready_i));
  assign accept     = grant_vld && can_accept;

  always_comb begin
    bus.req_ready_o = '0;
    if (accept) bus.req_ready_o[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset_i) begin
    if (!n_reset_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // last_q always equals the accepted ID while in EXEC, so it doubles as the owner ID.
  always_ff @(posedge clk or negedge n_reset_i) begin
    if (!n_reset_i) begin
      last_q       <= ID_W'(NUM_REQ - 1);
      alu_rd_q     <= '0;
      alu_rs_q     <= '0;
      alu_op_q     <= kADDU;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
      rsp_jump_q   <= 1'b0;
    end else begin
      if (accept) begin
        last_q   <= grant;
        alu_rd_q <= bus.req_rd_i[grant];
        alu_rs_q <= bus.req_rs_i[grant];
        alu_op_q <= bus.req_op_i[grant];
      end
      if (state_q == EXEC) begin
        rsp_result_q <= bus.alu_result_i;
        rsp_jump_q   <= bus.alu_jump_now_i;
        rsp_id_q     <= last_q;
      end
    end
  end

  assign bus.alu_rd_o     = alu_rd_q;
  assign bus.alu_rs_o     = alu_rs_q;
  assign bus.alu_op_o     = alu_op_q;
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.rsp_id_o     = rsp_id_q;
  assign bus.rsp_result_o = rsp_result_q;
  assign bus.rsp_jump_o   = rsp_jump_q;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between `NUM_REQ` requesters (e.g. the scalar pipe and the barrier/network units) through valid/ready handshakes. It arbitrates, registers the winner's operands onto the ALU inputs, and captures `result_o`/`jump_now_o` one cycle later. It returns the result with the requester's ID on a shared response channel, which has back-pressure. The block sits between issue logic and the `alu` instance; the `alu` itself is unchanged.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `n_reset_i` input 1: reset, asynchronous, active-low.
- `req_valid_i` input `NUM_REQ`: per-requester operation valid.
- `req_ready_o` output `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_rd_i` input `NUM_REQ`x32: rd operand per requester.
- `req_rs_i` input `NUM_REQ`x32: rs operand per requester.
- `req_op_i` input `NUM_REQ` x `instruction_s`: instruction per requester.
- `alu_rd_o` output 32: registered rd to `alu.rd_i`.
- `alu_rs_o` output 32: registered rs to `alu.rs_i`.
- `alu_op_o` output `instruction_s`: registered instruction to `alu.op_i`.
- `alu_result_i` input 32: from `alu.result_o`.
- `alu_jump_now_i` input 1: from `alu.jump_now_o`.
- `rsp_valid_o` output 1: response valid.
- `rsp_ready_i` input 1: response consumer ready.
- `rsp_id_o` output `ID_W`: index of the requester that owns the response.
- `rsp_result_o` output 32: captured ALU result.
- `rsp_jump_o` output 1: captured jump flag.

## Operation
- The FSM has three states:
  - **IDLE**: nothing in flight.
  - **EXEC**: operands are registered and the ALU is evaluating.
  - **RESP**: the response register is full.
- The grant is computed combinationally from `req_valid_i` every cycle. It is used only when the block can accept: in state IDLE, or in RESP with `rsp_ready_i`=1.
- Accept: `req_ready_o[g]`=1 for the winner `g` only, and only when the block can accept. The handshake completes when `req_valid_i[g]` and `req_ready_o[g]` are both 1.
  - On handshake, `alu_rd_o`/`alu_rs_o`/`alu_op_o` load requester `g`'s operands and instruction, the owner ID loads `g`, and the state goes to EXEC.
- **EXEC** always lasts exactly one cycle. `alu_result_i` and `alu_jump_now_i` are captured into `rsp_result_o` and `rsp_jump_o`, `rsp_id_o` takes the owner ID, and the state goes to RESP.
- **RESP**: `rsp_valid_o`=1.
  - If `rsp_ready_i`=0: hold all response outputs stable, no accepts.
  - If `rsp_ready_i`=1 and a grant exists: retire the response and accept the new operation in the same edge → EXEC.
  - If `rsp_ready_i`=1 and no grant exists: → IDLE.
- The ALU input registers hold their last value in all states other than an accept. The ALU inputs are never zeroed between operations.
- Requesters must hold `req_*` stable while valid and not accepted. The arbiter does not latch unaccepted requests.
- Arbitration pointer `last_q` (`ID_W` bits): updated to `g` on every accept.
- `rsp_valid_o` is never asserted in IDLE or EXEC.

## Timing
- Reset values: state=IDLE, `req_ready_o`=0, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_result_o`=0, `rsp_jump_o`=0, `alu_rd_o`=0, `alu_rs_o`=0, `alu_op_o`=0, `last_q`=`NUM_REQ`-1.
- Reset asserted mid-operation drops any in-flight operation and response immediately (asynchronous). Nothing is replayed.
- `req_ready_o` may be asserted combinationally while `n_reset_i`=1. It is 0 during reset.
- Latency: accept at edge N → `rsp_valid_o`=1 in the cycle after edge N+1.
- Throughput: with `rsp_ready_i` tied high and requests always pending, one accept every 2 cycles.
- The ALU critical path is bounded to one full cycle: register → alu → register.
- Simultaneous response retire and new accept in RESP is required; no bubble cycle through IDLE.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. Search starts at index `last_q`+1 and wraps modulo `NUM_REQ`; the first valid requester wins. The just-served requester has lowest priority next time.
- `ALU_ARB_RR_EN` undefined: fixed priority. The lowest index valid requester wins. `last_q` is still updated but ignored.

## Test plan
- Reset: drive `n_reset_i`=0 with all `req_valid_i`=1 → all outputs at reset values, `req_ready_o`=0. Release reset → `req_ready_o`=4'b0001 (RR and fixed).
- Single op: req 2, kADDU, rd=5, rs=7, `rsp_ready_i`=1 → `rsp_valid_o` in the cycle after the edge following accept, with `rsp_result_o`=12, `rsp_id_o`=2, `rsp_jump_o`=0.
- Jump: req 1, kBEQZ, rd=0 → `rsp_jump_o`=1, `rsp_result_o`=0. Then rd=3 → `rsp_jump_o`=0.
- Back-pressure: `rsp_ready_i`=0 for 5 cycles while req 0..3 are valid → response stable, `req_ready_o`=0 throughout. Raise `rsp_ready_i` → retire and next accept happen on the same edge.
- Arbitration: all 4 requesters continuously valid, 8 ops.
  - With `ALU_ARB_RR_EN`: `rsp_id_o` sequence 0,1,2,3,0,1,2,3.
  - Without it: 0,0,0,... If req 0 drops after its first op, then 1,1,...
- Mid-op reset: assert `n_reset_i`=0 during EXEC with kSUBU 9-4 → no response is ever produced. After release, a new kOR 0xF0|0x0F gives `rsp_result_o`=0xFF.
